// File: rtl/nibble_serial_subtractor_pkg.sv
// Shared definitions for the nibble-serial subtractor: FSM encoding and slice widths.
package nibble_serial_subtractor_pkg;

  // Width of one arithmetic slice and of its raw difference (borrow in bit 4).
  localparam int unsigned NIBBLE_W = 4;
  localparam int unsigned SLICE_W  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_sub_slice.sv
// Combinational 4-bit borrow-ripple subtract slice: {bo, d} = a - b - bi.
module nibble_sub_slice
  import nibble_serial_subtractor_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                bi,
  output logic [NIBBLE_W-1:0] d,
  output logic                bo
);

  logic [SLICE_W-1:0] diff;

  // Zero-extended subtraction; a negative result wraps and sets the top bit as borrow.
  always_comb begin
    diff = {1'b0, a} - {1'b0, b} - {{(SLICE_W-1){1'b0}}, bi};
    d    = diff[NIBBLE_W-1:0];
    bo   = diff[SLICE_W-1];
  end

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle subtractor D = A - B - Bin, one nibble per clock, LSB nibble first.
// A single nibble_sub_slice is reused; the borrow rides between cycles in a register.
// Optional Z/N result flags are built when SUB_FLAGS_EN is defined.
module nibble_serial_subtractor
  import nibble_serial_subtractor_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [NIBBLE_W*NIBBLES-1:0] A,
  input  logic [NIBBLE_W*NIBBLES-1:0] B,
  input  logic                        Bin,
  output logic                        busy,
  output logic                        done,
  output logic [NIBBLE_W*NIBBLES-1:0] D,
  output logic                        Bout,
`ifdef SUB_FLAGS_EN
  output logic                        Z,
  output logic                        N,
`endif
  output logic                        ovf
);

  localparam int unsigned WIDTH = NIBBLE_W * NIBBLES;
  localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   d_q, d_d;
  logic               borrow_q, borrow_d;
  logic               bout_q, bout_d;
  logic               ovf_q, ovf_d;
`ifdef SUB_FLAGS_EN
  logic               z_q, z_d;
  logic               n_q, n_d;
`endif

  logic [NIBBLE_W-1:0] a_nib;
  logic [NIBBLE_W-1:0] b_nib;
  logic [NIBBLE_W-1:0] slice_d;
  logic                slice_bo;
  logic                last_nib;

  // Select the operand nibbles addressed by the index with constant part-selects.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_nib = a_q[i*NIBBLE_W +: NIBBLE_W];
        b_nib = b_q[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  assign last_nib = (idx_q == IDX_W'(NIBBLES - 1));

  nibble_sub_slice u_slice (
    .a  (a_nib),
    .b  (b_nib),
    .bi (borrow_q),
    .d  (slice_d),
    .bo (slice_bo)
  );

  // Next-state logic: capture on start, process one nibble per RUN cycle, then pulse DONE.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    d_d      = d_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
`ifdef SUB_FLAGS_EN
    z_d      = z_q;
    n_d      = n_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = A;
          b_d      = B;
          borrow_d = Bin;
          idx_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < NIBBLES; i++) begin
          if (idx_q == IDX_W'(i)) begin
            d_d[i*NIBBLE_W +: NIBBLE_W] = slice_d;
          end
        end
        borrow_d = slice_bo;
        idx_d    = idx_q + IDX_W'(1);
        if (last_nib) begin
          bout_d  = slice_bo;
          // Signed overflow: operands of opposite sign and the result sign differs from A.
          ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (slice_d[NIBBLE_W-1] != a_q[WIDTH-1]);
`ifdef SUB_FLAGS_EN
          z_d     = (d_d == '0);
          n_d     = slice_d[NIBBLE_W-1];
`endif
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      d_q      <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef SUB_FLAGS_EN
      z_q      <= 1'b0;
      n_q      <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      d_q      <= d_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
`ifdef SUB_FLAGS_EN
      z_q      <= z_d;
      n_q      <= n_d;
`endif
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign D    = d_q;
  assign Bout = bout_q;
  assign ovf  = ovf_q;
`ifdef SUB_FLAGS_EN
  assign Z    = z_q;
  assign N    = n_q;
`endif

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Self-checking bench for nibble_serial_subtractor (NIBBLES=4): directed corner cases,
// randomized operands against a whole-word arithmetic model, ignored start and reset abort.
module tb_nibble_serial_subtractor;

  localparam int unsigned NIBBLES = 4;
  localparam int unsigned W       = 4 * NIBBLES;
  localparam int unsigned BUDGET  = 50;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Bin;
  logic         busy;
  logic         done;
  logic [W-1:0] D;
  logic         Bout;
  logic         ovf;
`ifdef SUB_FLAGS_EN
  logic         Z;
  logic         N;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nibble_serial_subtractor #(.NIBBLES(NIBBLES)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .busy  (busy),
    .done  (done),
    .D     (D),
    .Bout  (Bout),
`ifdef SUB_FLAGS_EN
    .Z     (Z),
    .N     (N),
`endif
    .ovf   (ovf)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one operation from IDLE and compare against whole-word arithmetic.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    logic [W:0] full;
    logic [W-1:0] exp_d;
    logic exp_bout, exp_ovf;
    int cycles;
    full     = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
    exp_d    = full[W-1:0];
    exp_bout = full[W];
    exp_ovf  = (a[W-1] != b[W-1]) && (exp_d[W-1] != a[W-1]);
    A = a; B = b; Bin = bi; start = 1'b1;
    tick();
    start = 1'b0;
    A = W'($urandom); B = W'($urandom); Bin = 1'($urandom);
    check("busy_run", {63'd0, busy}, 64'd1);
    cycles = 0;
    while (!done && cycles < BUDGET) begin
      tick();
      cycles++;
    end
    check("latency", 64'(cycles), 64'(NIBBLES));
    check("busy_done", {63'd0, busy}, 64'd0);
    check("D", 64'(D), 64'(exp_d));
    check("Bout", {63'd0, Bout}, {63'd0, exp_bout});
    check("ovf", {63'd0, ovf}, {63'd0, exp_ovf});
`ifdef SUB_FLAGS_EN
    check("Z", {63'd0, Z}, {63'd0, (exp_d == '0)});
    check("N", {63'd0, N}, {63'd0, exp_d[W-1]});
`endif
    tick();
    check("done_pulse", {63'd0, done}, 64'd0);
    check("D_hold", 64'(D), 64'(exp_d));
  endtask

  initial begin
    int pulses;
    logic [W-1:0] d_at_done;
    rst = 1'b1; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_D", 64'(D), 64'd0);
    check("rst_Bout", {63'd0, Bout}, 64'd0);
    check("rst_ovf", {63'd0, ovf}, 64'd0);

    // Reset dominates a simultaneous start.
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    check("rst_start_busy", {63'd0, busy}, 64'd0);

    // Directed corner cases.
    run_op(16'h1234, 16'h0235, 1'b0);
    check("dir_D_0fff", 64'(D), 64'h0FFF);
    run_op(16'h0000, 16'h0001, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b0);
    run_op(16'h7FFF, 16'hFFFF, 1'b0);
    run_op(16'h0005, 16'h0003, 1'b1);
    run_op(16'hABCD, 16'hABCD, 1'b0);
    run_op(16'h0000, 16'h0000, 1'b1);
    run_op(16'hFFFF, 16'hFFFF, 1'b1);

    // Randomized operands.
    for (int i = 0; i < 40; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom));
    end

    // Start pulsed again during RUN must be ignored.
    A = 16'h1000; B = 16'h0001; Bin = 1'b0; start = 1'b1;
    tick();
    A = 16'hFFFF; B = 16'h1234; Bin = 1'b1;
    pulses = 0;
    d_at_done = '0;
    for (int i = 0; i < 12; i++) begin
      if (i == 2) start = 1'b0;
      tick();
      if (done) begin
        pulses++;
        d_at_done = D;
      end
    end
    check("ign_pulses", 64'(pulses), 64'd1);
    check("ign_D", 64'(d_at_done), 64'h0FFF);

    // Reset in the second RUN cycle aborts with no done.
    A = 16'h5678; B = 16'h1111; Bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_D", 64'(D), 64'd0);
    check("abort_Bout", {63'd0, Bout}, 64'd0);
    check("abort_ovf", {63'd0, ovf}, 64'd0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done || busy) pulses++;
    end
    check("abort_quiet", 64'(pulses), 64'd0);
    run_op(16'h5678, 16'h1111, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
